// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// uart_rx_param: oversampled UART receiver with programmable data width,
// parity and stop bits. The serial line is synchronised, each bit is decided
// by a 3-sample majority vote around mid-bit, and results are presented with
// framing/parity/break/overrun status and a read handshake.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RxDataIn,
  input  logic                 RxRead,
  output logic [DATA_BITS-1:0] RxDataOut,
  output logic                 RxDone,
  output logic                 RxValid,
  output logic                 RxFrameError,
  output logic                 RxParityError,
  output logic                 RxBreak,
  output logic                 RxOverrun,
  output logic                 RxBusy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  // Majority of three line samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent for this data word.
  function automatic logic par_exp(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~(^d) : (^d);
  endfunction

  logic rx_p0, rx_p1;
  logic rxs;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [IW-1:0]       idx;
  logic                stop_idx;
  logic                fe_pend;
  logic                pe_pend;
  logic                par_zero;
  logic                smp_a, smp_b;
  logic                vote;
  logic                at_dec, at_last;
  logic                brk_now;
  logic [DATA_BITS-1:0] shreg;

  // Two-flop synchroniser; idles high so reset release never looks like a start.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= RxDataIn;
      rx_p1 <= rx_p0;
    end
  end

  assign rxs = rx_p1;

  // ---- bit timing / vote (combinational view of the current bit period) ----
  assign at_dec  = (cnt == CNT_DEC);
  assign at_last = (cnt == CNT_LAST);
  assign cnt_nxt = at_last ? '0 : cnt + 1'b1;
  assign vote    = maj3(smp_a, smp_b, rxs);
  // Break: every data bit, the parity bit (if any) and the final stop vote low.
  assign brk_now = (shreg == '0) && par_zero && !vote;

  // Capture the two early samples of each bit and shift decided data bits in LSB-first.
  always_ff @(posedge Clock) begin
    if (cnt == CNT_S0) smp_a <= rxs;
    if (cnt == CNT_S1) smp_b <= rxs;
    if (state == S_DATA && at_dec) shreg <= {vote, shreg[DATA_BITS-1:1]};
  end

  // Receive FSM with registered status outputs and the consumer handshake.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= '0;
      stop_idx      <= 1'b0;
      fe_pend       <= 1'b0;
      pe_pend       <= 1'b0;
      par_zero      <= 1'b0;
      RxDataOut     <= '0;
      RxDone        <= 1'b0;
      RxValid       <= 1'b0;
      RxFrameError  <= 1'b0;
      RxParityError <= 1'b0;
      RxBreak       <= 1'b0;
      RxOverrun     <= 1'b0;
    end else begin
      RxDone <= 1'b0;
      if (RxRead) begin
        RxValid   <= 1'b0;
        RxOverrun <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            // The detecting cycle counts as cnt = 0 of the start bit.
            state    <= S_START;
            cnt      <= CNT_ONE;
            idx      <= '0;
            stop_idx <= 1'b0;
            fe_pend  <= 1'b0;
            pe_pend  <= 1'b0;
            par_zero <= 1'b1;
          end
        end
        S_START: begin
          cnt <= cnt_nxt;
          if (at_dec && vote) begin
            // Start bit did not hold low through mid-bit: treat as a glitch.
            state <= S_IDLE;
            cnt   <= '0;
          end else if (at_last) begin
            state <= S_DATA;
            idx   <= '0;
          end
        end
        S_DATA: begin
          cnt <= cnt_nxt;
          if (at_last) begin
            if (idx == IDX_LAST) state <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                 idx   <= idx + 1'b1;
          end
        end
        S_PARITY: begin
          cnt <= cnt_nxt;
          if (at_dec) begin
            par_zero <= ~vote;
            if (vote != par_exp(shreg)) pe_pend <= 1'b1;
          end
          if (at_last) state <= S_STOP;
        end
        S_STOP: begin
          cnt <= cnt_nxt;
          if (at_last) stop_idx <= 1'b1;
          if (at_dec) begin
            if (stop_idx == STOP_LAST) begin
              // Frame complete at the last stop decision; no waiting out the bit.
              state         <= brk_now ? S_BRK_WAIT : S_IDLE;
              cnt           <= '0;
              RxDone        <= 1'b1;
              RxDataOut     <= shreg;
              RxFrameError  <= fe_pend | ~vote;
              RxParityError <= pe_pend;
              RxBreak       <= brk_now;
              RxValid       <= 1'b1;
              RxOverrun     <= RxValid & ~RxRead;
            end else if (!vote) begin
              fe_pend <= 1'b1;
            end
          end
        end
        S_BRK_WAIT: begin
          cnt <= '0;
          if (rxs) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign RxBusy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Bench for uart_rx_param: an 8N1 instance and a 7E2 instance driven with
// directed and random frames; expectations are queued per frame and checked
// by a monitor whenever RxDone pulses.
module tb_uart_rx_param;

  localparam int CPB_A = 16, DB_A = 8, PAR_A = 0, ST_A = 1;
  localparam int CPB_B = 8,  DB_B = 7, PAR_B = 1, ST_B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rd_a = 1'b0, rx_b = 1'b1, rd_b = 1'b0;
  logic [DB_A-1:0] dout_a;
  logic [DB_B-1:0] dout_b;
  logic done_a, vld_a, fe_a, pe_a, brk_a, ovr_a, busy_a;
  logic done_b, vld_b, fe_b, pe_b, brk_b, ovr_b, busy_b;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int unread [2];

  typedef struct {
    int data;
    bit fe;
    bit pe;
    bit brk;
    bit ovr;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  uart_rx_param #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A), .PARITY(PAR_A), .STOP_BITS(ST_A)) dut_a (
    .Clock(clk), .Reset(rst_n), .RxDataIn(rx_a), .RxRead(rd_a),
    .RxDataOut(dout_a), .RxDone(done_a), .RxValid(vld_a), .RxFrameError(fe_a),
    .RxParityError(pe_a), .RxBreak(brk_a), .RxOverrun(ovr_a), .RxBusy(busy_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B), .PARITY(PAR_B), .STOP_BITS(ST_B)) dut_b (
    .Clock(clk), .Reset(rst_n), .RxDataIn(rx_b), .RxRead(rd_b),
    .RxDataOut(dout_b), .RxDone(done_b), .RxValid(vld_b), .RxFrameError(fe_b),
    .RxParityError(pe_b), .RxBreak(brk_b), .RxOverrun(ovr_b), .RxBusy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, expv);
    end
  endtask

  // Monitor: every RxDone must match the oldest queued frame expectation.
  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL A unexpected RxDone (cycle %0d): got data %0d, expected no frame", cyc, dout_a);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("A data", int'(dout_a), e.data);
        chk("A frame_err", int'(fe_a), int'(e.fe));
        chk("A parity_err", int'(pe_a), int'(e.pe));
        chk("A break", int'(brk_a), int'(e.brk));
        chk("A overrun", int'(ovr_a), int'(e.ovr));
        chk("A valid", int'(vld_a), 1);
        chk("A done cycle", cyc, e.cyc);
      end
    end
    if (done_b) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL B unexpected RxDone (cycle %0d): got data %0d, expected no frame", cyc, dout_b);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("B data", int'(dout_b), e.data);
        chk("B frame_err", int'(fe_b), int'(e.fe));
        chk("B parity_err", int'(pe_b), int'(e.pe));
        chk("B break", int'(brk_b), int'(e.brk));
        chk("B overrun", int'(ovr_b), int'(e.ovr));
        chk("B valid", int'(vld_b), 1);
        chk("B done cycle", cyc, e.cyc);
      end
    end
  end

  task automatic hold(input int inst, input logic v, input int n);
    if (inst == 0) rx_a = v;
    else           rx_b = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transmit one frame and queue what the receiver must report for it.
  task automatic send(input int inst, input int d, input bit bad_par, input bit stop_low);
    int cpb, nb, par, nst, nbits, dm;
    logic pb;
    exp_t e;
    if (inst == 0) begin cpb = CPB_A; nb = DB_A; par = PAR_A; nst = ST_A; end
    else           begin cpb = CPB_B; nb = DB_B; par = PAR_B; nst = ST_B; end
    dm = d & ((1 << nb) - 1);
    pb = (($countones(dm) % 2) == 1);
    if (par == 2) pb = ~pb;
    if (bad_par)  pb = ~pb;
    nbits = 1 + nb + ((par != 0) ? 1 : 0) + nst;
    e.data = dm;
    e.fe   = stop_low;
    e.pe   = (par != 0) && bad_par;
    e.brk  = (dm == 0) && (par == 0 || pb == 1'b0) && stop_low;
    e.ovr  = (unread[inst] != 0);
    e.cyc  = cyc + 2 + (nbits - 1) * cpb + cpb / 2 + 2;
    if (inst == 0) qa.push_back(e);
    else           qb.push_back(e);
    hold(inst, 1'b0, cpb);
    for (int i = 0; i < nb; i++) hold(inst, dm[i], cpb);
    if (par != 0) hold(inst, pb, cpb);
    for (int s = 0; s < nst; s++) hold(inst, (stop_low && s == nst - 1) ? 1'b0 : 1'b1, cpb);
    if (stop_low) hold(inst, 1'b1, cpb);
    unread[inst] = 1;
  endtask

  task automatic do_read(input int inst);
    if (inst == 0) rd_a = 1'b1;
    else           rd_b = 1'b1;
    @(posedge clk);
    #1;
    rd_a = 1'b0;
    rd_b = 1'b0;
    if (inst == 0) begin
      chk("A valid after read", int'(vld_a), 0);
      chk("A overrun after read", int'(ovr_a), 0);
    end else begin
      chk("B valid after read", int'(vld_b), 0);
      chk("B overrun after read", int'(ovr_b), 0);
    end
    unread[inst] = 0;
  endtask

  initial begin
    int e0;
    exp_t eb;
    unread[0] = 0;
    unread[1] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("A reset outputs", int'({dout_a, done_a, vld_a, fe_a, pe_a, brk_a, ovr_a, busy_a}), 0);
    chk("B reset outputs", int'({dout_b, done_b, vld_b, fe_b, pe_b, brk_b, ovr_b, busy_b}), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("A no start after reset", int'(busy_a), 0);

    // 8N1 basic frame
    send(0, 'hA5, 1'b0, 1'b0);
    do_read(0);
    hold(0, 1'b1, 5);

    // Stop bit low, non-zero data: framing error only
    send(0, 'h3C, 1'b0, 1'b1);
    do_read(0);
    hold(0, 1'b1, CPB_A);

    // Line held low for 20 bit times: a single break frame
    eb.data = 0; eb.fe = 1'b1; eb.pe = 1'b0; eb.brk = 1'b1; eb.ovr = 1'b0;
    eb.cyc  = cyc + 2 + 9 * CPB_A + CPB_A / 2 + 2;
    qa.push_back(eb);
    hold(0, 1'b0, 20 * CPB_A);
    chk("A busy in break wait", int'(busy_a), 1);
    hold(0, 1'b1, 3 * CPB_A);
    unread[0] = 1;
    do_read(0);
    send(0, 'h55, 1'b0, 1'b0);
    do_read(0);
    hold(0, 1'b1, 4);

    // 3-cycle low glitch in idle
    hold(0, 1'b0, 3);
    chk("A busy during glitch start", int'(busy_a), 1);
    hold(0, 1'b1, 9);
    chk("A busy after glitch", int'(busy_a), 0);
    hold(0, 1'b1, CPB_A);

    // Back-to-back frames with no read: overrun
    send(0, 'h11, 1'b0, 1'b0);
    send(0, 'h22, 1'b0, 1'b0);
    chk("A overrun data", int'(dout_a), 'h22);
    chk("A overrun flag", int'(ovr_a), 1);
    chk("A overrun valid", int'(vld_a), 1);
    do_read(0);

    // Random 8N1 frames with random gaps and reads
    for (int k = 0; k < 8; k++) begin
      hold(0, 1'b1, $urandom_range(0, 5));
      send(0, $urandom_range(0, 255), 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) do_read(0);
    end
    if (unread[0] != 0) do_read(0);

    // 7E2: wrong parity, correct parity, second stop bit low
    hold(1, 1'b1, 10);
    send(1, 'h41, 1'b1, 1'b0);
    chk("B parity data", int'(dout_b), 'h41);
    do_read(1);
    send(1, 'h41, 1'b0, 1'b0);
    do_read(1);
    send(1, 'h2A, 1'b0, 1'b1);
    do_read(1);
    for (int k = 0; k < 6; k++) begin
      hold(1, 1'b1, $urandom_range(0, 3));
      send(1, $urandom_range(0, 127), $urandom_range(0, 1) == 1, 1'b0);
      if ($urandom_range(0, 1) == 1) do_read(1);
    end

    // Reset in the middle of a data bit, with a frame left unread
    hold(0, 1'b1, 4);
    send(0, 'h96, 1'b0, 1'b0);
    hold(0, 1'b1, 2);
    hold(0, 1'b0, CPB_A);
    hold(0, 1'b1, CPB_A);
    hold(0, 1'b0, 5);
    chk("A busy before reset", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk("A outputs in reset", int'({dout_a, done_a, vld_a, fe_a, pe_a, brk_a, ovr_a, busy_a}), 0);
    chk("B outputs in reset", int'({dout_b, done_b, vld_b, fe_b, pe_b, brk_b, ovr_b, busy_b}), 0);
    rx_a = 1'b1;
    unread[0] = 0;
    unread[1] = 0;
    e0 = 3;
    repeat (e0) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    hold(0, 1'b1, 4);
    send(0, 'hC3, 1'b0, 1'b0);
    do_read(0);

    // Everything queued must have been seen
    hold(0, 1'b1, 2 * CPB_A);
    chk("A frames outstanding", qa.size(), 0);
    chk("B frames outstanding", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: next-generation serial receive block for the UART subsystem. Single-clock, oversampled by a programmable clock-per-bit divisor. Adds:
- configurable data width, parity and stop-bit count;
- input synchronisation and 3-sample majority voting;
- separate framing, parity, break and overrun status;
- a read handshake to the consumer.

## Interface
Parameters:
- CLKS_PER_BIT, 16, Clock cycles per bit; legal range ≥ 4.
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- Clock  in  1  Sole clock; all logic on the rising edge.
- Reset  in  1  Asynchronous, active-low reset.
- RxDataIn  in  1  Serial line; idles high.
- RxRead  in  1  Consumer read strobe; clears RxValid and RxOverrun.
- RxDataOut  out  DATA_BITS  Last received word, LSB = first bit on the line.
- RxDone  out  1  One-cycle pulse per completed frame, including errored frames.
- RxValid  out  1  Set with RxDone; held until RxRead.
- RxFrameError  out  1  Last frame had a stop bit sampled low.
- RxParityError  out  1  Last frame failed its parity check.
- RxBreak  out  1  Last frame was a break.
- RxOverrun  out  1  A frame completed while RxValid was still set.
- RxBusy  out  1  High in any state other than IDLE.

## Operation
Input path:
- RxDataIn passes through a 2-flop synchroniser; both flops reset to 1.
- All logic below uses the synchronised line (rxs).

Counters:
- Bit-period counter: cnt, width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps.
- HALF = CLKS_PER_BIT/2 (integer division).
- Samples are taken at cnt = HALF-1, HALF and HALF+1.
- The bit value is the majority of those three samples, decided at cnt = HALF+1.
- Bit index: width $clog2(DATA_BITS+1).

State machine:
- IDLE: on rxs = 0 → START with cnt = 0.
- START:
  - If the vote is 1 → IDLE. This is a glitch: no RxDone, no flags.
  - Otherwise at cnt = CLKS_PER_BIT-1 → DATA with bit index 0.
- DATA:
  - Each bit vote is shifted in LSB-first.
  - After bit DATA_BITS-1 completes its period → PARITY if PARITY ≠ 0, else STOP.
- PARITY: the vote is compared with even or odd parity over the data bits; a mismatch sets the pending parity error.
- STOP:
  - A vote of 0 on any stop bit sets the pending framing error.
  - With STOP_BITS = 2, the first stop bit runs its full period.
  - At the last stop bit's decision (cnt = HALF+1), the frame completes. The FSM goes → IDLE, or → BRK_WAIT if break.
  - The FSM does not wait out the rest of the stop bit.
- Break: all data bits 0, parity bit 0 (if present), and the last stop vote 0.
  - Sets RxBreak and RxFrameError.
  - → BRK_WAIT.
- BRK_WAIT: stays until rxs = 1, then → IDLE. No new start detection while in BRK_WAIT.

Frame completion (cycle after the decision):
- RxDone pulses.
- RxDataOut is loaded with the received bits, even on error.
- RxFrameError, RxParityError and RxBreak are replaced with this frame's values.
- RxValid ← 1.
- RxOverrun ← 1 if RxValid was already 1 and RxRead is low that cycle.
- If RxRead and completion coincide: RxValid stays 1 and no overrun is flagged.

Other rules:
- RxRead with no completion: RxValid ← 0, RxOverrun ← 0.
- The three error flags hold until the next completion.
- Reset (any time, including mid-frame): state = IDLE; counters 0; every output 0; synchroniser flops 1.
- On release of reset, no false start is detected from the reset value.

## Timing
- Input-to-rxs latency: 2 Clock cycles.
- T0 is the first cycle rxs = 0 in IDLE (cnt = 0).
- Decision for bit k (k = 0 is start) occurs at T0 + k·CLKS_PER_BIT + HALF + 1.
- Let N = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS. RxDone is high at T0 + (N-1)·CLKS_PER_BIT + HALF + 2.
- The next start can be detected from the cycle after the final decision.
- RxBusy = 1 from T0+1 until the cycle the FSM re-enters IDLE.

## Test plan
- 8N1, CLKS_PER_BIT = 16, byte 0xA5, line edge at cycle E:
  - RxDone at E + 2 + 154, RxDataOut = 0xA5.
  - RxValid = 1, all error flags 0.
- 7E2, data 0x41, parity bit forced wrong → RxParityError = 1, RxFrameError = 0, RxDataOut = 0x41.
- 8N1, stop bit driven low, data 0x3C → RxFrameError = 1, RxBreak = 0, RxDataOut = 0x3C.
- Line held low for 20 bit times → one RxDone with RxDataOut = 0, RxBreak = 1, RxFrameError = 1.
  - No further frames until the line returns high, then a normal 0x55 frame is received.
- Low glitch of 3 cycles in IDLE → no RxDone; RxBusy drops within HALF+2 cycles.
- Overrun and reset:
  - Two back-to-back frames 0x11, 0x22 with no RxRead → RxDataOut = 0x22, RxOverrun = 1; one RxRead clears RxValid and RxOverrun.
  - Reset asserted mid-data → all outputs 0 immediately; the next clean frame is received correctly.
